// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache tag engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef struct packed {
        logic hit;
        logic evict;
        logic wb;
    } rsp_t;

    function automatic int off_w(input int linesize);
        return $clog2(linesize);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int address_size, input int sets, input int linesize);
        return address_size - $clog2(sets) - $clog2(linesize);
    endfunction

    // Way/age fields keep at least one bit so a direct-mapped build still elaborates.
    function automatic int way_w(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_update.sv
// True-LRU age update for one set, plus the current eviction candidate.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the new ages.
module cache_lru_update
    import cache_pkg::*;
#(
    parameter int ASSOC = 2,
    parameter int WW    = way_w(ASSOC)
) (
    input  logic [ASSOC-1:0][WW-1:0] age_in,
    input  logic [WW-1:0]            way,
    output logic [ASSOC-1:0][WW-1:0] age_out,
    output logic [WW-1:0]            victim
);

    logic [WW-1:0] old_age;

    // Accessed way becomes youngest; every younger way ages by one.
    always_comb begin
        old_age = age_in[way];
        age_out = age_in;
        for (int w = 0; w < ASSOC; w++) begin
            if (WW'(w) == way) begin
                age_out[w] = '0;
            end else if (age_in[w] < old_age) begin
                age_out[w] = age_in[w] + WW'(1);
            end
        end
    end

    // Victim is the oldest way; it depends only on stored ages, never on the chosen way.
    always_comb begin
        victim = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (age_in[w] == WW'(ASSOC - 1)) begin
                victim = WW'(w);
            end
        end
    end

endmodule

// File: rtl/cache_tag_engine.sv
// Tag/valid/dirty/LRU engine for a set-associative write-back write-allocate cache.
// Latency: accept at edge N, response valid after edge N+1; dirty misses insert a writeback first.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
module cache_tag_engine
    import cache_pkg::*;
#(
    parameter int SETS         = 16,
    parameter int ASSOC        = 2,
    parameter int LINESIZE     = 16,
    parameter int ADDRESS_SIZE = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ADDRESS_SIZE-1:0] wb_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    output logic                    rsp_evict,
    output logic                    rsp_wb,
    input  logic                    stats_clear,
    output logic [CNT_WIDTH-1:0]    cnt_access,
    output logic [CNT_WIDTH-1:0]    cnt_read,
    output logic [CNT_WIDTH-1:0]    cnt_write,
    output logic [CNT_WIDTH-1:0]    cnt_hit,
    output logic [CNT_WIDTH-1:0]    cnt_miss,
    output logic [CNT_WIDTH-1:0]    cnt_evict,
    output logic [CNT_WIDTH-1:0]    cnt_wb
);

    localparam int OFF  = off_w(LINESIZE);
    localparam int IDX  = idx_w(SETS);
    localparam int TAGW = tag_w(ADDRESS_SIZE, SETS, LINESIZE);
    localparam int WW   = way_w(ASSOC);
    localparam int LW   = ADDRESS_SIZE - OFF;

    state_t                          state_q, state_d;
    logic                            rw_q;
    logic [LW-1:0]                   line_q;
    logic [SETS-1:0][ASSOC-1:0][TAGW-1:0] tag_mem;
    logic [SETS-1:0][ASSOC-1:0]      valid_mem;
    logic [SETS-1:0][ASSOC-1:0]      dirty_mem;
    logic [SETS-1:0][ASSOC-1:0][WW-1:0] age_mem;
    rsp_t                            rsp_q;
    logic [ADDRESS_SIZE-1:0]         wb_addr_q;

    logic [IDX-1:0]                  idx;
    logic [TAGW-1:0]                 tag;
    logic                            hit, inv_found, evict, wb;
    logic [WW-1:0]                   hit_way, inv_way, way, victim;
    logic [ASSOC-1:0][WW-1:0]        age_new;

    // Byte offset never influences tag state; only the line address is kept.
    logic unused_offset_bits;
    assign unused_offset_bits = ^req_addr[OFF-1:0];

    assign idx = line_q[IDX-1:0];
    assign tag = line_q[LW-1:IDX];

    assign rsp_hit   = rsp_q.hit;
    assign rsp_evict = rsp_q.evict;
    assign rsp_wb    = rsp_q.wb;
    assign wb_addr   = wb_addr_q;

    // Tag compare and lowest-index free way; descending scan lets the lowest index win.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_mem[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    // Way selection: hit way, else free way, else the LRU victim.
    always_comb begin
        way   = hit ? hit_way : (inv_found ? inv_way : victim);
        evict = !hit && !inv_found;
        wb    = evict && dirty_mem[idx][victim];
    end

    cache_lru_update #(
        .ASSOC (ASSOC),
        .WW    (WW)
    ) u_lru (
        .age_in  (age_mem[idx]),
        .way     (way),
        .age_out (age_new),
        .victim  (victim)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wb_valid  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                state_d = wb ? WRITEBACK : RESPOND;
            end
            WRITEBACK: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = RESPOND;
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q   <= READ;
            line_q <= '0;
        end else if ((state_q == IDLE) && req_valid) begin
            rw_q   <= req_rw;
            line_q <= req_addr[ADDRESS_SIZE-1:OFF];
        end
    end

    // Valid, dirty and LRU state; reset invalidates everything and restores age = way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_mem <= '0;
            dirty_mem <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    age_mem[s][w] <= WW'(w);
                end
            end
        end else if (state_q == LOOKUP) begin
            valid_mem[idx][way] <= 1'b1;
            dirty_mem[idx][way] <= hit ? (dirty_mem[idx][way] | (rw_q == WRITE)) : (rw_q == WRITE);
            age_mem[idx]        <= age_new;
        end
    end

    // Tag storage needs no reset: entries are meaningless while their valid bit is clear.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP) tag_mem[idx][way] <= tag;
    end

    // Response flags and victim line address, held stable until consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q     <= '0;
            wb_addr_q <= '0;
        end else if (state_q == LOOKUP) begin
            rsp_q <= '{hit: hit, evict: evict, wb: wb};
            if (wb) wb_addr_q <= {tag_mem[idx][victim], idx, {OFF{1'b0}}};
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Saturating statistics; a clear overrides the increment of the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stats_clear) begin
            cnt_access <= '0;
            cnt_read   <= '0;
            cnt_write  <= '0;
            cnt_hit    <= '0;
            cnt_miss   <= '0;
            cnt_evict  <= '0;
            cnt_wb     <= '0;
        end else if (state_q == LOOKUP) begin
            cnt_access <= sat_inc(cnt_access);
            if (rw_q == WRITE) cnt_write <= sat_inc(cnt_write);
            else               cnt_read  <= sat_inc(cnt_read);
            if (hit) cnt_hit  <= sat_inc(cnt_hit);
            else     cnt_miss <= sat_inc(cnt_miss);
            if (evict) cnt_evict <= sat_inc(cnt_evict);
            if (wb)    cnt_wb    <= sat_inc(cnt_wb);
        end
    end

endmodule

// File: tb/tb_cache_tag_engine.sv
// Directed bench: instance 0 uses default parameters, instance 1 uses ASSOC=4, CNT_WIDTH=4.
// Latency: checks response/writeback timing relative to request acceptance.
// Backpressure: exercises held wb_ready and reset during a pending writeback.
module tb_cache_tag_engine;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic clk;
    logic reset;

    logic [1:0]  req_valid_s, req_ready_s, req_rw_s;
    logic [1:0]  wb_valid_s, wb_ready_s;
    logic [1:0]  rsp_valid_s, rsp_ready_s, rsp_hit_s, rsp_evict_s, rsp_wb_s;
    logic [1:0]  stats_clear_s;
    logic [15:0] req_addr_s [2];
    logic [15:0] wb_addr_s  [2];

    logic [31:0] a_access, a_read, a_write, a_hit, a_miss, a_evict, a_wb;
    logic [3:0]  b_access, b_read, b_write, b_hit, b_miss, b_evict, b_wb;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_tag_engine u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_rw(req_rw_s[0]), .req_addr(req_addr_s[0]),
        .wb_valid(wb_valid_s[0]), .wb_ready(wb_ready_s[0]), .wb_addr(wb_addr_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_hit(rsp_hit_s[0]), .rsp_evict(rsp_evict_s[0]), .rsp_wb(rsp_wb_s[0]),
        .stats_clear(stats_clear_s[0]),
        .cnt_access(a_access), .cnt_read(a_read), .cnt_write(a_write), .cnt_hit(a_hit),
        .cnt_miss(a_miss), .cnt_evict(a_evict), .cnt_wb(a_wb)
    );

    cache_tag_engine #(.ASSOC(4), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_rw(req_rw_s[1]), .req_addr(req_addr_s[1]),
        .wb_valid(wb_valid_s[1]), .wb_ready(wb_ready_s[1]), .wb_addr(wb_addr_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_hit(rsp_hit_s[1]), .rsp_evict(rsp_evict_s[1]), .rsp_wb(rsp_wb_s[1]),
        .stats_clear(stats_clear_s[1]),
        .cnt_access(b_access), .cnt_read(b_read), .cnt_write(b_write), .cnt_hit(b_hit),
        .cnt_miss(b_miss), .cnt_evict(b_evict), .cnt_wb(b_wb)
    );

    // One full transaction on instance d. rsp = {hit, evict, wb}; wb_lat = -1 if no writeback.
    // wb_lat/rsp_lat count falling edges after the accepting edge (rsp_lat after the wb handshake).
    task automatic run_req(input int d, input logic rw, input logic [15:0] addr, input int wb_hold,
                           input logic clr, output logic [2:0] rsp, output logic [15:0] wba,
                           output int wb_lat, output int rsp_lat, output logic held_ok);
        int k;
        rsp = '0; wba = '0; wb_lat = -1; rsp_lat = -1; held_ok = 1'b1;
        @(negedge clk);
        req_valid_s[d] = 1'b1;
        req_rw_s[d]    = rw;
        req_addr_s[d]  = addr;
        k = 0;
        while (!req_ready_s[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        req_valid_s[d] = 1'b0;
        if (clr) stats_clear_s[d] = 1'b1;
        k = 1;
        while (!rsp_valid_s[d] && !wb_valid_s[d] && k < 50) begin
            @(negedge clk);
            stats_clear_s[d] = 1'b0;
            k++;
        end
        stats_clear_s[d] = 1'b0;
        if (wb_valid_s[d]) begin
            wb_lat = k;
            wba    = wb_addr_s[d];
            for (int i = 0; i < wb_hold; i++) begin
                @(negedge clk);
                if (!wb_valid_s[d] || rsp_valid_s[d]) held_ok = 1'b0;
            end
            wb_ready_s[d] = 1'b1;
            @(negedge clk);
            wb_ready_s[d] = 1'b0;
            k = 1;
            while (!rsp_valid_s[d] && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        rsp_lat = k;
        if (rsp_valid_s[d]) begin
            rsp = {rsp_hit_s[d], rsp_evict_s[d], rsp_wb_s[d]};
            rsp_ready_s[d] = 1'b1;
            @(negedge clk);
            rsp_ready_s[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid_s = '0; req_rw_s = '0; wb_ready_s = '0; rsp_ready_s = '0; stats_clear_s = '0;
        req_addr_s[0] = '0; req_addr_s[1] = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready_s !== 2'b11) begin n_fail++; $display("FAIL reset_req_ready: got %b want 11", req_ready_s); end
        n_cmp++;
        if ({wb_valid_s, rsp_valid_s} !== 4'b0) begin n_fail++; $display("FAIL reset_valids: got %b want 0000", {wb_valid_s, rsp_valid_s}); end
        n_cmp++;
        if ({rsp_hit_s, rsp_evict_s, rsp_wb_s} !== 6'b0) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 0", {rsp_hit_s, rsp_evict_s, rsp_wb_s}); end
        n_cmp++;
        if (wb_addr_s[0] !== 16'h0) begin n_fail++; $display("FAIL reset_wb_addr: got %h want 0000", wb_addr_s[0]); end
        n_cmp++;
        if ({a_access, a_read, a_write, a_hit, a_miss, a_evict, a_wb} !== 224'b0) begin n_fail++; $display("FAIL reset_cnt_a: got nonzero counter, access %0d hit %0d miss %0d", a_access, a_hit, a_miss); end
        n_cmp++;
        if ({b_access, b_read, b_write, b_hit, b_miss, b_evict, b_wb} !== 28'b0) begin n_fail++; $display("FAIL reset_cnt_b: got %h want 0", {b_access, b_read, b_write, b_hit, b_miss, b_evict, b_wb}); end
        reset = 1'b1;
    endtask

    task automatic test_cold_warm();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        run_req(0, RD, 16'h0010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b000) begin n_fail++; $display("FAIL cold_rsp: got %b want 000", rsp); end
        n_cmp++;
        if (rl !== 2 || wl !== -1) begin n_fail++; $display("FAIL cold_latency: got rsp %0d wb %0d want 2 -1", rl, wl); end
        run_req(0, RD, 16'h0010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b100) begin n_fail++; $display("FAIL warm_rsp: got %b want 100", rsp); end
        n_cmp++;
        if (rl !== 2) begin n_fail++; $display("FAIL warm_latency: got %0d want 2", rl); end
        n_cmp++;
        if (a_access !== 32'd2 || a_hit !== 32'd1 || a_miss !== 32'd1 || a_read !== 32'd2) begin
            n_fail++; $display("FAIL cold_warm_cnt: got acc %0d hit %0d miss %0d rd %0d want 2 1 1 2", a_access, a_hit, a_miss, a_read);
        end
    endtask

    task automatic test_dirty_evict();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        run_req(0, WR, 16'h0010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b100) begin n_fail++; $display("FAIL write_hit_rsp: got %b want 100", rsp); end
        run_req(0, RD, 16'h1010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b000) begin n_fail++; $display("FAIL fill_way1_rsp: got %b want 000", rsp); end
        run_req(0, RD, 16'h2010, 3, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (wl !== 2 || wba !== 16'h0010) begin n_fail++; $display("FAIL dirty_wb: got lat %0d addr %h want 2 0010", wl, wba); end
        n_cmp++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL wb_hold: got %b want 1", held); end
        n_cmp++;
        if (rl !== 1 || rsp !== 3'b011) begin n_fail++; $display("FAIL dirty_rsp: got lat %0d rsp %b want 1 011", rl, rsp); end
        n_cmp++;
        if (a_evict !== 32'd1 || a_wb !== 32'd1 || a_write !== 32'd1 || a_miss !== 32'd3 || a_hit !== 32'd2) begin
            n_fail++; $display("FAIL dirty_cnt: got ev %0d wb %0d wr %0d miss %0d hit %0d want 1 1 1 3 2", a_evict, a_wb, a_write, a_miss, a_hit);
        end
    endtask

    task automatic test_lru();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        logic [15:0] addrs [7] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0000, 16'h4000, 16'h0000};
        logic [2:0]  exps  [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b100};
        for (int i = 0; i < 7; i++) begin
            run_req(1, RD, addrs[i], 0, 1'b0, rsp, wba, wl, rl, held);
            n_cmp++;
            if (rsp !== exps[i] || wl !== -1) begin
                n_fail++; $display("FAIL lru_step%0d addr %h: got rsp %b wb %0d want %b -1", i, addrs[i], rsp, wl, exps[i]);
            end
        end
        // 0x1000 was the victim, so 0x2000 must still be resident.
        run_req(1, RD, 16'h2000, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b100) begin n_fail++; $display("FAIL lru_survivor: got %b want 100", rsp); end
        n_cmp++;
        if (b_access !== 4'd8 || b_hit !== 4'd3 || b_miss !== 4'd5 || b_evict !== 4'd1) begin
            n_fail++; $display("FAIL lru_cnt: got acc %0d hit %0d miss %0d ev %0d want 8 3 5 1", b_access, b_hit, b_miss, b_evict);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        int hits;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            run_req(1, RD, 16'h0000, 0, 1'b0, rsp, wba, wl, rl, held);
            if (rsp === 3'b100) hits++;
        end
        n_cmp++;
        if (hits !== 20) begin n_fail++; $display("FAIL sat_hits: got %0d want 20", hits); end
        n_cmp++;
        if (b_access !== 4'd15 || b_hit !== 4'd15 || b_read !== 4'd15) begin
            n_fail++; $display("FAIL sat_cnt: got acc %0d hit %0d rd %0d want 15 15 15", b_access, b_hit, b_read);
        end
        n_cmp++;
        if (b_miss !== 4'd5 || b_write !== 4'd0 || b_wb !== 4'd0) begin
            n_fail++; $display("FAIL sat_other: got miss %0d wr %0d wb %0d want 5 0 0", b_miss, b_write, b_wb);
        end
    endtask

    task automatic test_clear();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        run_req(1, RD, 16'h0000, 0, 1'b1, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b100) begin n_fail++; $display("FAIL clear_rsp: got %b want 100", rsp); end
        n_cmp++;
        if ({b_access, b_read, b_write, b_hit, b_miss, b_evict, b_wb} !== 28'b0) begin
            n_fail++; $display("FAIL clear_wins: got %h want 0", {b_access, b_read, b_write, b_hit, b_miss, b_evict, b_wb});
        end
        run_req(1, RD, 16'h0000, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (b_access !== 4'd1 || b_hit !== 4'd1) begin n_fail++; $display("FAIL after_clear: got acc %0d hit %0d want 1 1", b_access, b_hit); end
    endtask

    task automatic test_reset_midop();
        logic [2:0] rsp; logic [15:0] wba; int wl, rl; logic held;
        run_req(0, WR, 16'h1010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b100) begin n_fail++; $display("FAIL mid_write_hit: got %b want 100", rsp); end
        run_req(0, WR, 16'h3010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b010) begin n_fail++; $display("FAIL mid_clean_evict: got %b want 010", rsp); end
        @(negedge clk);
        req_valid_s[0] = 1'b1; req_rw_s[0] = RD; req_addr_s[0] = 16'h4010;
        @(negedge clk);
        req_valid_s[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb_valid_s[0] !== 1'b1 || wb_addr_s[0] !== 16'h1010) begin
            n_fail++; $display("FAIL mid_wb_pending: got vld %b addr %h want 1 1010", wb_valid_s[0], wb_addr_s[0]);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (wb_valid_s[0] !== 1'b0 || rsp_valid_s[0] !== 1'b0 || req_ready_s !== 2'b11) begin
            n_fail++; $display("FAIL mid_reset_drop: got wb %b rsp %b rdy %b want 0 0 11", wb_valid_s[0], rsp_valid_s[0], req_ready_s);
        end
        @(negedge clk);
        reset = 1'b1;
        run_req(0, RD, 16'h3010, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b000 || wl !== -1) begin n_fail++; $display("FAIL post_reset_a: got rsp %b wb %0d want 000 -1", rsp, wl); end
        run_req(1, RD, 16'h0000, 0, 1'b0, rsp, wba, wl, rl, held);
        n_cmp++;
        if (rsp !== 3'b000) begin n_fail++; $display("FAIL post_reset_b: got %b want 000", rsp); end
        n_cmp++;
        if (a_access !== 32'd1 || a_miss !== 32'd1 || a_wb !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_cnt: got acc %0d miss %0d wb %0d want 1 1 0", a_access, a_miss, a_wb);
        end
    endtask

    initial begin
        test_reset();
        test_cold_warm();
        test_dirty_evict();
        test_lru();
        test_saturation();
        test_clear();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
